// File: rtl/serial_io_pkg.sv
// Shared types and constants for the serial I/O block: UART FSM states and LFSR setup.
// Purely declarative; no logic, no latency, no flow control.
package serial_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int          DATA_BITS = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] l);
    return ^(l & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: full_tick every DIV clocks, half_tick at DIV/2 - 1.
// Combinational ticks from the count register; clear restarts the period; no backpressure.
module uart_bit_timer #(
  parameter int DIV = 208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic full_tick,
  output logic half_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign full_tick = (cnt_q == LAST);
  assign half_tick = (cnt_q == HALF);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || full_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_io_core.sv
// 8N1 UART TX/RX with valid/ready handshakes plus a 16-bit LFSR random bit.
// TX start bit one cycle after accept; RX byte lands at mid-stop; rx_valid sticky until rx_ready.
module serial_io_core
  import serial_io_pkg::*;
#(
  parameter int CLOCK_RATE = 24000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       tx_ready,
  input  logic       rx_enable,
  input  logic       rx_in,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_overrun,
  output logic       random_bit
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        tx_out_q, tx_out_d;
  logic        tx_ready_q, tx_ready_d;
  logic        tx_tick, tx_half_unused, tx_timer_clr;

  uart_state_t rx_state_q, rx_state_d;
  logic [1:0]  rx_sync_q, rx_sync_d;
  logic        rx_prev_q, rx_prev_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_error_q, rx_error_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        rx_line, rx_full, rx_half, rx_timer_clr;

  logic [15:0] lfsr_q, lfsr_d;

  assign tx_timer_clr = (tx_state_q == IDLE);

  uart_bit_timer #(.DIV(DIV)) u_tx_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (tx_timer_clr),
    .full_tick (tx_tick),
    .half_tick (tx_half_unused)
  );

  uart_bit_timer #(.DIV(DIV)) u_rx_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (rx_timer_clr),
    .full_tick (rx_full),
    .half_tick (rx_half)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_out_d   = tx_out_q;
    tx_ready_d = tx_ready_q;
    case (tx_state_q)
      IDLE: begin
        tx_out_d   = 1'b1;
        tx_ready_d = tx_enable;
        if (tx_valid && tx_ready_q) begin
          tx_shift_d = tx_data;
          tx_ready_d = 1'b0;
          tx_out_d   = 1'b0;
          tx_state_d = START;
        end
      end
      START: if (tx_tick) begin
        tx_out_d   = tx_shift_q[0];
        tx_idx_d   = '0;
        tx_state_d = DATA;
      end
      DATA: if (tx_tick) begin
        if (tx_idx_q == LAST_BIT) begin
          tx_out_d   = 1'b1;
          tx_state_d = STOP;
        end else begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_out_d   = tx_shift_q[1];
          tx_idx_d   = tx_idx_q + 3'd1;
        end
      end
      STOP: if (tx_tick) begin
        tx_state_d = IDLE;
        tx_ready_d = tx_enable;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  assign rx_sync_d = {rx_sync_q[0], rx_in};
  assign rx_line   = rx_sync_q[1];
  assign rx_prev_d = rx_line;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_shift_d   = rx_shift_q;
    rx_idx_d     = rx_idx_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q && !rx_ready;
    rx_error_d   = 1'b0;
    rx_overrun_d = 1'b0;
    rx_timer_clr = 1'b0;
    if (!rx_enable) begin
      rx_state_d   = IDLE;
      rx_timer_clr = 1'b1;
    end else begin
      case (rx_state_q)
        IDLE: begin
          rx_timer_clr = 1'b1;
          if (rx_prev_q && !rx_line) rx_state_d = START;
        end
        // Restart the timer at mid-start so later full ticks land mid-bit.
        START: if (rx_half) begin
          if (!rx_line) begin
            rx_state_d   = DATA;
            rx_timer_clr = 1'b1;
            rx_idx_d     = '0;
          end else begin
            rx_state_d = IDLE;
          end
        end
        DATA: if (rx_full) begin
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_idx_q == LAST_BIT) rx_state_d = STOP;
          else                      rx_idx_d   = rx_idx_q + 3'd1;
        end
        STOP: if (rx_full) begin
          rx_state_d = IDLE;
          if (rx_line) begin
            rx_data_d    = rx_shift_q;
            rx_valid_d   = 1'b1;
            rx_overrun_d = rx_valid_q && !rx_ready;
          end else begin
            rx_error_d = 1'b1;
          end
        end
        default: rx_state_d = IDLE;
      endcase
    end
  end

  assign lfsr_d = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q   <= IDLE;
      tx_shift_q   <= '0;
      tx_idx_q     <= '0;
      tx_out_q     <= 1'b1;
      tx_ready_q   <= 1'b0;
      rx_state_q   <= IDLE;
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_shift_q   <= '0;
      rx_idx_q     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_error_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_shift_q   <= tx_shift_d;
      tx_idx_q     <= tx_idx_d;
      tx_out_q     <= tx_out_d;
      tx_ready_q   <= tx_ready_d;
      rx_state_q   <= rx_state_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_shift_q   <= rx_shift_d;
      rx_idx_q     <= rx_idx_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_error_q   <= rx_error_d;
      rx_overrun_q <= rx_overrun_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_error   = rx_error_q;
  assign rx_overrun = rx_overrun_q;
  assign random_bit = lfsr_q[0];

endmodule

// File: tb/tb_serial_io_core.sv
// Bench for serial_io_core: directed TX/RX frames, expected responses queued for TX/RX monitors.
// LFSR, reset and tx_ready timing are compared directly against hand-derived values.
module tb_serial_io_core;

  localparam int DIV = 208;

  typedef struct packed {
    logic [1:0] kind;  // 0 byte delivered, 1 framing error, 2 overrun
    logic [7:0] data;
  } rx_ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_enable = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_enable = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic       tx_out, tx_ready, rx_valid, rx_error, rx_overrun, random_bit;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] tx_q[$];
  rx_ev_t     rx_q[$];

  always #5 clk = ~clk;

  serial_io_core #(.CLOCK_RATE(24000000), .BAUD_RATE(115200)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_out     (tx_out),
    .tx_ready   (tx_ready),
    .rx_enable  (rx_enable),
    .rx_in      (rx_in),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error),
    .rx_overrun (rx_overrun),
    .random_bit (random_bit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic rx_event(input logic [1:0] kind, input logic [7:0] data);
    rx_ev_t e;
    if (rx_q.size() == 0) begin
      n_checks++;
      $display("FAIL rx_unexpected_event: got kind %0d data 0x%0h, required no event (t=%0t)", kind, data, $time);
    end else begin
      e = rx_q.pop_front();
      check("rx_event_kind", 32'(kind), 32'(e.kind));
      if (e.kind != 2'd1) check("rx_event_data", 32'(data), 32'(e.data));
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      repeat (DIV) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic count_ready_low(output int n, input int drop_at);
    n = 0;
    while (!tx_ready && n < 5000) begin
      if (n == drop_at) tx_valid = 1'b0;
      n++;
      @(negedge clk);
    end
  endtask

  // TX monitor: every cycle of a frame must match the expected bit cell.
  initial begin : tx_mon
    logic [9:0] f;
    logic [7:0] dec, eb;
    int         bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx_out == 1'b0) begin
        if (tx_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected_frame: got a start bit, required idle line (t=%0t)", $time);
          repeat (10 * DIV) @(negedge clk);
        end else begin
          eb = tx_q[0];
          f = {1'b1, eb, 1'b0};
          bad = 0;
          dec = 8'h00;
          aborted = 1'b0;
          for (int i = 0; i < 10 * DIV && !aborted; i++) begin
            if (i > 0) @(negedge clk);
            if (reset) aborted = 1'b1;
            else begin
              if (tx_out !== f[i / DIV]) bad++;
              if (i % DIV == DIV / 2 && i / DIV >= 1 && i / DIV <= 8) dec[i / DIV - 1] = tx_out;
            end
          end
          void'(tx_q.pop_front());
          if (!aborted) begin
            check("tx_byte", 32'(dec), 32'(eb));
            check("tx_bad_bit_cycles", 32'(bad), 32'd0);
          end
        end
      end
    end
  end

  initial begin : rx_mon
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rx_error)           rx_event(2'd1, rx_data);
        if (rx_overrun)         rx_event(2'd2, rx_data);
        if (rx_valid && !pv)    rx_event(2'd0, rx_data);
      end
      pv = rx_valid;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] m;
    int          n;

    @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_random_bit", 32'(random_bit), 32'd1);

    reset = 1'b0;
    m = 16'hACE1;
    check("lfsr_bit", 32'(random_bit), 32'(m[0]));
    m = lfsr_next(m);
    @(negedge clk);
    check("tx_ready_first_cycle", 32'(tx_ready), 32'd1);
    for (int i = 1; i < 20; i++) begin
      check("lfsr_bit", 32'(random_bit), 32'(m[0]));
      m = lfsr_next(m);
      @(negedge clk);
    end

    // TX 0x4F, valid for one cycle
    tx_q.push_back(8'h4F);
    tx_data  = 8'h4F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    count_ready_low(n, -1);
    check("tx_ready_low_cycles", 32'(n), 32'd2080);
    repeat (5) @(negedge clk);

    // RX 0xA5, held until consumed
    rx_q.push_back('{kind: 2'd0, data: 8'hA5});
    send_rx(8'hA5, 1'b1);
    repeat (50) @(negedge clk);
    check("rx_valid_held", 32'(rx_valid), 32'd1);
    check("rx_data_held", 32'(rx_data), 32'hA5);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("rx_valid_after_consume", 32'(rx_valid), 32'd0);

    // Framing error, then a short glitch
    rx_q.push_back('{kind: 2'd1, data: 8'h00});
    send_rx(8'h55, 1'b0);
    check("rx_valid_after_ferr", 32'(rx_valid), 32'd0);
    rx_in = 1'b0;
    repeat (50) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("rx_valid_after_glitch", 32'(rx_valid), 32'd0);

    // Overrun: two frames without consuming
    rx_q.push_back('{kind: 2'd0, data: 8'h30});
    send_rx(8'h30, 1'b1);
    rx_q.push_back('{kind: 2'd2, data: 8'h31});
    send_rx(8'h31, 1'b1);
    check("overrun_rx_valid", 32'(rx_valid), 32'd1);
    check("overrun_rx_data", 32'(rx_data), 32'h31);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    // Reset in the middle of a TX frame
    tx_q.push_back(8'hC3);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (500) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midframe_rst_tx_out", 32'(tx_out), 32'd1);
    check("midframe_rst_tx_ready", 32'(tx_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Next byte after release, valid held past acceptance
    tx_q.push_back(8'h96);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tx_ready_after_reset", 32'(tx_ready), 32'd1);
    @(negedge clk);
    count_ready_low(n, 100);
    tx_valid = 1'b0;
    check("tx_ready_low_cycles_2", 32'(n), 32'd2080);
    repeat (20) @(negedge clk);

    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
